// File: rtl/ab_encoder.sv
// ab_encoder: packs A/B set-points into W = A*RADIX + B with a shift-add multiplier
module ab_encoder #(
  parameter int RADIX = 64,
  parameter int WW    = 13,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] A_val,
  input  logic [AW-1:0] B_val,
  output logic [WW-1:0] W,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int ACCW = 2*AW+1;
  localparam int IW   = $clog2(AW);
  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;
  state_t          r_state, w_next;
  logic [AW-1:0]   r_a, r_b;
  logic [IW-1:0]   r_idx;
  logic [ACCW-1:0] r_acc;
  logic            r_chk, r_done, r_err;
  logic [WW-1:0]   r_w;
  logic [ACCW-1:0] w_radix, w_sum;
  logic            w_over;
  assign w_radix = ACCW'(RADIX);
  assign w_sum   = r_acc + ACCW'(r_b);
  assign w_over  = (r_b >= AW'(RADIX)) || (w_sum > ACCW'((1 << WW) - 1));
  assign W    = r_w;
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign err  = r_err;
  // next state: one pass through the bits of A, then add B, then report
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? MUL : IDLE;
      MUL:     w_next = (r_idx == IW'(AW-1)) ? ADD : MUL;
      ADD:     w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // state register and datapath; W only changes on an error-free result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_chk   <= 1'b0;
      r_w     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == DONE;
      case (r_state)
        IDLE: if (start) begin
          r_a   <= A_val;
          r_b   <= B_val;
          r_acc <= '0;
          r_idx <= '0;
          r_err <= 1'b0;
        end
        MUL: begin
          r_acc <= r_a[r_idx] ? r_acc + (w_radix << r_idx) : r_acc;
          r_idx <= r_idx + 1'b1;
        end
        ADD: begin
          r_acc <= w_sum;
          r_chk <= w_over;
        end
        default: begin
          r_err <= r_chk;
          if (!r_chk) r_w <= r_acc[WW-1:0];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ab_encoder.sv
// tb_ab_encoder: randomized scoreboard bench for ab_encoder against an arithmetic model
module tb_ab_encoder;
  localparam int RADIX = 64;
  logic clk = 0, reset = 1, start = 0;
  logic [6:0] a_val = 0, b_val = 0;
  logic [12:0] w;
  logic busy, done, err;
  int total = 0, bad = 0;
  int exp_w = 0;
  bit exp_e = 0;
  typedef struct {int w; bit e;} exp_t;
  exp_t q[$];

  ab_encoder #(.RADIX(RADIX), .WW(13), .AW(7)) dut (
    .clk(clk), .reset(reset), .start(start), .A_val(a_val), .B_val(b_val),
    .W(w), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic push(input int a, input int b);
    int v = a * RADIX + b;
    exp_e = (b >= RADIX) || (v > 8191);
    if (!exp_e) exp_w = v;
    q.push_back('{exp_w, exp_e});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        x = q.pop_front();
        chk("W", int'(w), x.w);
        chk("err", int'(err), int'(x.e));
      end
    end
  end

  task automatic conv(input int a, input int b, input bit poke);
    a_val = 7'(a);
    b_val = 7'(b);
    start = 1;
    push(a, b);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("busy", int'(busy), 1);
      chk("done_early", int'(done), 0);
      if (i == 0) begin
        start = 0;
        a_val = 7'($urandom);
        b_val = 7'($urandom);
      end
      if (poke && i == 3) start = 1;
      if (poke && i == 4) start = 0;
    end
    step();
    chk("done", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    step();
    chk("done_pulse", int'(done), 0);
    chk("W_hold", int'(w), exp_w);
    chk("err_hold", int'(err), int'(exp_e));
  endtask

  initial begin
    int a, b;
    step();
    step();
    chk("rst_W", int'(w), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    reset = 0;
    step();
    conv(3, 5, 0);
    conv(127, 63, 0);
    conv(0, 0, 0);
    conv(3, 5, 0);
    conv(1, 64, 0);
    conv(0, 63, 1);
    conv(127, 64, 0);
    conv(127, 127, 0);
    conv(100, 0, 1);
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 127));
      b = ($urandom % 2) ? int'($urandom_range(0, RADIX - 1)) : int'($urandom_range(0, 127));
      conv(a, b, n % 3 == 0);
    end
    a = int'($urandom_range(0, 127));
    b = int'($urandom_range(0, RADIX - 1));
    a_val = 7'(a);
    b_val = 7'(b);
    start = 1;
    for (int k = 0; k < 3; k++) push(a, b);
    for (int c = 0; c < 32; c++) begin
      step();
      chk("b2b_done", int'(done), int'(c == 9 || c == 19 || c == 29));
      if (c == 20) start = 0;
    end
    conv(3, 5, 0);
    a_val = 7'd10;
    b_val = 7'd1;
    start = 1;
    push(10, 1);
    step();
    start = 0;
    step();
    step();
    step();
    reset = 1;
    q.delete();
    exp_w = 0;
    exp_e = 0;
    step();
    chk("abort_busy", int'(busy), 0);
    chk("abort_W", int'(w), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_done", int'(done), 0);
    reset = 0;
    for (int c = 0; c < 12; c++) step();
    conv(3, 5, 0);
    conv(0, 200 % 128, 0);
    step();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
